// File: rtl/bus_fanout_5_pkg.sv
// bus_fanout_5_pkg: destination count, FSM state encoding and reset values shared by the fanout block
package bus_fanout_5_pkg;
  localparam int NR_OF_DEST = 5;
  typedef enum logic {IDLE = 1'b0, DELIVER = 1'b1} state_t;
  localparam logic [31:0] DATA_RST = '0;
  localparam logic [NR_OF_DEST-1:0] PENDING_RST = '0;
endpackage

// File: rtl/bus_fanout_5_dest_slot.sv
// fanout_dest_slot: one destination's pending bit; load sets it, valid&ready clears it; ports clock, reset, load, ready -> valid
module fanout_dest_slot #(
  parameter logic RST = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic ready,
  output logic valid
);
  always_ff @(posedge clock or posedge reset)
    if (reset) valid <= RST;
    else valid <= load | (valid & ~ready);
endmodule

// File: rtl/bus_fanout_5.sv
// bus_fanout_5: latches one bus word and delivers it to a masked subset of 5 valid/ready destinations; in_* source side, out_* destination side, busy/dropped status
module bus_fanout_5
  import bus_fanout_5_pkg::*;
#(
  parameter int NrOfBits = 32,
  parameter int NrOfDest = NR_OF_DEST
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NrOfBits-1:0] in_data,
  input  logic [NrOfDest-1:0] in_dest,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NrOfBits-1:0] out_data,
  output logic [NrOfDest-1:0] out_valid,
  input  logic [NrOfDest-1:0] out_ready,
  output logic                busy,
  output logic                dropped
);
  state_t state;
  logic accept;
  logic [NrOfDest-1:0] load;
  logic [NrOfDest-1:0] remain;
  always_comb begin
    in_ready = state == IDLE;
    busy = state == DELIVER;
    accept = in_valid & in_ready;
    load = accept ? in_dest : '0;
    remain = out_valid & ~out_ready;
  end
  for (genvar i = 0; i < NrOfDest; i++) begin : g_slot
    fanout_dest_slot #(.RST(PENDING_RST[i])) u_slot (
      .clock(clock),
      .reset(reset),
      .load (load[i]),
      .ready(out_ready[i]),
      .valid(out_valid[i])
    );
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      out_data <= NrOfBits'(DATA_RST);
      dropped <= 1'b0;
    end else begin
      dropped <= accept & ~|in_dest;
      if (accept & |in_dest) begin
        out_data <= in_data;
        state <= DELIVER;
      end else if (busy & ~|remain) state <= IDLE;
    end
endmodule
